// File: rtl/pingpong_sram_sched.sv
`default_nettype none
// =============================================================================
// Module   : pingpong_sram_sched
// Purpose  : Ping-pong scheduler sharing one SRAM port between a producer that
//            fills one bank and a consumer that drains the other.
// Revision : 1.0 - initial release
// =============================================================================
module pingpong_sram_sched #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int OFIFO  = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q,
    output logic              CEN_EVEN,
    output logic              WEN_EVEN,
    output logic              CEN_ODD,
    output logic              WEN_ODD,
    output logic [1:0]        bank_full
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = (OFIFO > 1) ? $clog2(OFIFO) : 1;
    localparam int c_CW = $clog2(OFIFO + 1);

    localparam logic [c_AW-1:0] c_LAST_ENTRY = c_AW'(DEPTH - 1);
    localparam logic [c_PW-1:0] c_LAST_PTR   = c_PW'(OFIFO - 1);

    localparam logic [1:0] c_EMPTY    = 2'd0;
    localparam logic [1:0] c_FILLING  = 2'd1;
    localparam logic [1:0] c_FULL     = 2'd2;
    localparam logic [1:0] c_DRAINING = 2'd3;

    localparam logic c_GRANT_WR = 1'b0;
    localparam logic c_GRANT_RD = 1'b1;

    logic [1:0]        r_bank_state [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [c_AW-1:0]   r_wr_cnt;
    logic [c_AW-1:0]   r_rd_cnt;
    logic              r_inflight;
    logic [3:0]        r_last_addr;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_fifo_mem [OFIFO];
    logic [c_PW-1:0]   r_fifo_wptr;
    logic [c_PW-1:0]   r_fifo_rptr;
    logic [c_CW-1:0]   r_fifo_cnt;

    logic            w_hold;
    logic            w_wr_base;
    logic            w_wr_elig;
    logic            w_rd_avail;
    logic            w_rd_req;
    logic            w_rd_ok;
    logic            w_prio_rd;
    logic            w_pop;
    logic [c_CW:0]   w_credit_used;
    logic            w_wr_grant;
    logic            w_rd_grant;

    // The cycle after a read issue keeps A[3] on the read bank so the wrapper's Q mux stays valid.
    assign w_hold     = r_inflight;
    assign w_wr_base  = (r_bank_state[r_wr_bank] == c_EMPTY) || (r_bank_state[r_wr_bank] == c_FILLING);
    assign w_wr_elig  = w_wr_base && !w_hold;
    assign w_rd_avail = (r_bank_state[r_rd_bank] == c_FULL) || (r_bank_state[r_rd_bank] == c_DRAINING);

    assign rd_valid = (r_fifo_cnt != '0);
    assign rd_data  = r_fifo_mem[r_fifo_rptr];
    assign w_pop    = rd_valid && rd_ready;

    assign w_credit_used = {1'b0, r_fifo_cnt} + (c_CW+1)'(r_inflight) - (c_CW+1)'(w_pop);
    assign w_rd_req      = w_rd_avail && (w_credit_used < (c_CW+1)'(OFIFO));
    assign w_rd_ok       = w_rd_req && (!w_hold || (r_rd_bank == r_last_addr[3]));
    assign w_prio_rd     = (r_last_grant == c_GRANT_WR);

    assign wr_ready   = w_wr_elig && !(w_rd_ok && w_prio_rd);
    assign w_wr_grant = !reset && wr_valid && wr_ready;
    // A waiting writer that owns priority idles the hold cycle so the two sides alternate.
    assign w_rd_grant = !reset && w_rd_ok && !(wr_valid && w_wr_base && !w_prio_rd);

    assign bank_full[0] = (r_bank_state[0] == c_FULL) || (r_bank_state[0] == c_DRAINING);
    assign bank_full[1] = (r_bank_state[1] == c_FULL) || (r_bank_state[1] == c_DRAINING);

    always_comb begin
        A        = w_hold ? r_last_addr : 4'd0;
        D        = '0;
        CEN_EVEN = 1'b1;
        WEN_EVEN = 1'b1;
        CEN_ODD  = 1'b1;
        WEN_ODD  = 1'b1;
        if (w_wr_grant) begin
            A = {r_wr_bank, r_wr_cnt};
            D = wr_data;
            if (r_wr_bank) begin
                CEN_ODD = 1'b0;
                WEN_ODD = 1'b0;
            end else begin
                CEN_EVEN = 1'b0;
                WEN_EVEN = 1'b0;
            end
        end else if (w_rd_grant) begin
            A = {r_rd_bank, r_rd_cnt};
            if (r_rd_bank) begin
                CEN_ODD = 1'b0;
            end else begin
                CEN_EVEN = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_bank_state[0] <= c_EMPTY;
            r_bank_state[1] <= c_EMPTY;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_last_addr     <= 4'd0;
            r_last_grant    <= c_GRANT_WR;
            r_fifo_wptr     <= '0;
            r_fifo_rptr     <= '0;
            r_fifo_cnt      <= '0;
            for (int i = 0; i < OFIFO; i++) begin
                r_fifo_mem[i] <= '0;
            end
        end else begin
            if (w_wr_grant) begin
                if (r_wr_cnt == c_LAST_ENTRY) begin
                    r_wr_cnt                <= '0;
                    r_bank_state[r_wr_bank] <= c_FULL;
                    r_wr_bank               <= ~r_wr_bank;
                end else begin
                    r_wr_cnt                <= r_wr_cnt + c_AW'(1);
                    r_bank_state[r_wr_bank] <= c_FILLING;
                end
            end

            if (w_rd_grant) begin
                r_last_addr <= {r_rd_bank, r_rd_cnt};
                if (r_rd_cnt == c_LAST_ENTRY) begin
                    r_rd_cnt                <= '0;
                    r_bank_state[r_rd_bank] <= c_EMPTY;
                    r_rd_bank               <= ~r_rd_bank;
                end else begin
                    r_rd_cnt                <= r_rd_cnt + c_AW'(1);
                    r_bank_state[r_rd_bank] <= c_DRAINING;
                end
            end

            if (w_wr_grant || w_rd_grant) begin
                r_last_grant <= w_rd_grant ? c_GRANT_RD : c_GRANT_WR;
            end

            r_inflight <= w_rd_grant;

            // Q is valid the cycle after issue; credit accounting guarantees a free slot.
            if (r_inflight) begin
                r_fifo_mem[r_fifo_wptr] <= Q;
                r_fifo_wptr <= (r_fifo_wptr == c_LAST_PTR) ? '0 : r_fifo_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_fifo_rptr <= (r_fifo_rptr == c_LAST_PTR) ? '0 : r_fifo_rptr + c_PW'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + c_CW'(r_inflight) - c_CW'(w_pop);
        end
    end

endmodule
`default_nettype wire
